// File: rtl/cam_pkg.sv
// Shared definitions for the CAM match resolver: state encoding and default row count.
package cam_pkg;

    localparam int CAM_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        MISS = 2'd2
    } cam_st_e;

endpackage

// File: rtl/cam_priority_enc.sv
// Combinational lowest-set-bit encoder over a CAM row vector.
module cam_priority_enc #(
    parameter int CAM_DEPTH = 16,
    parameter int ADDR_W    = $clog2(CAM_DEPTH)
) (
    input  logic [CAM_DEPTH-1:0] vec,
    output logic [ADDR_W-1:0]    idx,
    output logic                 any
);

    logic [CAM_DEPTH-1:0] onehot;

    // Isolate the lowest set bit, then OR-reduce its index: log-depth, no priority chain.
    always_comb begin
        onehot = vec & (~vec + CAM_DEPTH'(1));
        idx    = '0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            if (onehot[i]) begin
                idx = idx | ADDR_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/cam_match_resolver.sv
// Serialises a captured CAM row_match vector into per-address responses, lowest row first.
// Optional CAM_MATCH_COUNT_EN adds a registered popcount output (match_count).
module cam_match_resolver
    import cam_pkg::*;
#(
    parameter int CAM_DEPTH = CAM_DEPTH_DEFAULT,
    parameter int ADDR_W    = $clog2(CAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 search_valid,
    output logic                 search_ready,
    input  logic [CAM_DEPTH-1:0] row_match,
    output logic                 match_valid,
    input  logic                 match_ready,
    output logic                 match_hit,
    output logic [ADDR_W-1:0]    match_addr,
    output logic                 match_last
`ifdef CAM_MATCH_COUNT_EN
    ,
    output logic [ADDR_W:0]      match_count
`endif
);

    cam_st_e              st, st_next;
    logic [CAM_DEPTH-1:0] pend, pend_next;
    logic [ADDR_W-1:0]    low_idx;
    logic                 low_any;
    logic                 pend_single;

    cam_priority_enc #(
        .CAM_DEPTH (CAM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_enc (
        .vec (pend),
        .idx (low_idx),
        .any (low_any)
    );

    assign pend_single = (pend & (pend - CAM_DEPTH'(1))) == '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st   <= IDLE;
            pend <= '0;
        end else begin
            st   <= st_next;
            pend <= pend_next;
        end
    end

    always_comb begin
        st_next      = st;
        pend_next    = pend;
        search_ready = 1'b0;
        match_valid  = 1'b0;
        match_hit    = 1'b0;
        match_addr   = '0;
        match_last   = 1'b0;
        case (st)
            IDLE: begin
                search_ready = 1'b1;
                if (search_valid) begin
                    pend_next = row_match;
                    st_next   = (|row_match) ? EMIT : MISS;
                end
            end
            EMIT: begin
                match_valid = 1'b1;
                match_hit   = low_any;
                match_addr  = low_idx;
                match_last  = pend_single;
                if (match_ready) begin
                    pend_next = pend & ~(CAM_DEPTH'(1) << low_idx);
                    if (pend_single) begin
                        st_next = IDLE;
                    end
                end
            end
            MISS: begin
                match_valid = 1'b1;
                match_last  = 1'b1;
                if (match_ready) begin
                    st_next = IDLE;
                end
            end
            default: st_next = IDLE;
        endcase
    end

`ifdef CAM_MATCH_COUNT_EN
    logic [ADDR_W:0] row_count;

    always_comb begin
        row_count = '0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            row_count = row_count + (ADDR_W+1)'(row_match[i]);
        end
    end

    // Held for the whole response sequence; only an accepted search updates it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_count <= '0;
        end else if (st == IDLE && search_valid) begin
            match_count <= row_count;
        end
    end
`endif

endmodule

// File: tb/tb_cam_match_resolver.sv
// Self-checking bench for cam_match_resolver: queue-based response model plus directed corners.
module tb_cam_match_resolver;

    localparam int D  = 16;
    localparam int AW = 4;
    localparam int WD = 256;
    localparam int WA = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          search_valid, search_ready, match_valid, match_ready;
    logic          match_hit, match_last;
    logic [D-1:0]  row_match;
    logic [AW-1:0] match_addr;
`ifdef CAM_MATCH_COUNT_EN
    logic [AW:0]   match_count;
`endif

    logic          w_search_valid, w_search_ready, w_match_valid, w_match_ready;
    logic          w_match_hit, w_match_last;
    logic [WD-1:0] w_row_match;
    logic [WA-1:0] w_match_addr;
`ifdef CAM_MATCH_COUNT_EN
    logic [WA:0]   w_match_count;
`endif

    cam_match_resolver #(.CAM_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .search_valid (search_valid),
        .search_ready (search_ready),
        .row_match    (row_match),
        .match_valid  (match_valid),
        .match_ready  (match_ready),
        .match_hit    (match_hit),
        .match_addr   (match_addr),
        .match_last   (match_last)
`ifdef CAM_MATCH_COUNT_EN
        ,
        .match_count  (match_count)
`endif
    );

    cam_match_resolver #(.CAM_DEPTH(WD)) dut_wide (
        .clk          (clk),
        .rst          (rst),
        .search_valid (w_search_valid),
        .search_ready (w_search_ready),
        .row_match    (w_row_match),
        .match_valid  (w_match_valid),
        .match_ready  (w_match_ready),
        .match_hit    (w_match_hit),
        .match_addr   (w_match_addr),
        .match_last   (w_match_last)
`ifdef CAM_MATCH_COUNT_EN
        ,
        .match_count  (w_match_count)
`endif
    );

    typedef struct packed {
        logic       hit;
        logic [7:0] addr;
        logic       last;
    } resp_t;

    resp_t exp_q[$];
    resp_t log_q[$];
    int    exp_cnt = 0;
    int    errors  = 0;
    int    checks  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a search becomes the list of its set rows (or one miss) consumed one per handshake.
    task automatic model_edge();
        resp_t r;
        int    n, k;
        if (exp_q.size() == 0) begin
            if (search_valid) begin
                n       = $countones(row_match);
                exp_cnt = n;
                k       = 0;
                for (int i = 0; i < D; i++) begin
                    if (row_match[i]) begin
                        k++;
                        r.hit  = 1'b1;
                        r.addr = 8'(i);
                        r.last = (k == n);
                        exp_q.push_back(r);
                    end
                end
                if (n == 0) begin
                    r.hit  = 1'b0;
                    r.addr = 8'd0;
                    r.last = 1'b1;
                    exp_q.push_back(r);
                end
            end
        end else if (match_ready) begin
            log_q.push_back(exp_q[0]);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic check_main();
        logic [7:0] exp_v;
        if (exp_q.size() == 0) exp_v = 8'b1_0_0_0000_0;
        else exp_v = {1'b0, 1'b1, exp_q[0].hit, exp_q[0].addr[AW-1:0], exp_q[0].last};
        chk("outputs", 64'({search_ready, match_valid, match_hit, match_addr, match_last}), 64'(exp_v));
`ifdef CAM_MATCH_COUNT_EN
        chk("match_count", 64'(match_count), 64'(exp_cnt));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_main();
    endtask

    task automatic wstep();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        search_valid   = 1'b0;
        match_ready    = 1'b0;
        row_match      = '0;
        w_search_valid = 1'b0;
        w_match_ready  = 1'b0;
        w_row_match    = '0;

        repeat (2) @(negedge clk);
        check_main();
        chk("reset_lit", 64'({search_ready, match_valid, match_hit, match_addr, match_last}), 64'(8'b1000_0000));
        rst = 1'b1;
        @(negedge clk);

        // miss
        row_match = 16'h0000; search_valid = 1'b1; match_ready = 1'b1;
        step();
        search_valid = 1'b0;
        chk("miss_resp", 64'({match_valid, match_hit, match_addr, match_last}), 64'(7'b1_0_0000_1));
        step();
        chk("miss_ready", 64'(search_ready), 64'(1));

        // multi-match ordering
        log_q.delete();
        row_match = 16'h8421; search_valid = 1'b1;
        step();
        search_valid = 1'b0;
`ifdef CAM_MATCH_COUNT_EN
        chk("count_8421", 64'(match_count), 64'(4));
`endif
        repeat (4) step();
        chk("order_n", 64'(log_q.size()), 64'(4));
        if (log_q.size() == 4) begin
            chk("order_addr", 64'({log_q[0].addr, log_q[1].addr, log_q[2].addr, log_q[3].addr}),
                64'({8'd0, 8'd5, 8'd10, 8'd15}));
            chk("order_last", 64'({log_q[0].last, log_q[1].last, log_q[2].last, log_q[3].last}),
                64'(4'b0001));
        end

        // backpressure, with ignored search pulses
        row_match = 16'h0006; search_valid = 1'b1; match_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            search_valid = (i != 1);
            row_match    = 16'hFFFF;
            step();
            chk("bp_hold", 64'({match_valid, match_addr, match_last}), 64'(6'b1_0001_0));
        end
        search_valid = 1'b0; match_ready = 1'b1;
        step();
        chk("bp_second", 64'({match_valid, match_addr, match_last}), 64'(6'b1_0010_1));
        step();

        // single top row
        row_match = 16'h8000; search_valid = 1'b1;
        step();
        search_valid = 1'b0;
        chk("top_row", 64'({match_hit, match_addr, match_last}), 64'(6'b1_1111_1));
        step();

        // reset mid-search
        row_match = 16'hFFFF; search_valid = 1'b1;
        step();
        search_valid = 1'b0;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        exp_cnt = 0;
        chk("rst_async", 64'({search_ready, match_valid, match_hit, match_addr, match_last}), 64'(8'b1000_0000));
        check_main();
        @(posedge clk);
        @(negedge clk);
        check_main();
        rst = 1'b1;
        row_match = 16'h0010; search_valid = 1'b1;
        step();
        search_valid = 1'b0;
        chk("post_rst", 64'({match_hit, match_addr, match_last}), 64'(6'b1_0100_1));
        step();
        chk("post_rst_idle", 64'({search_ready, match_valid}), 64'(2'b10));

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            search_valid = 1'($urandom_range(0, 1));
            match_ready  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: row_match = '0;
                1: row_match = D'(1) << $urandom_range(0, D - 1);
                2: row_match = D'($urandom & $urandom);
                default: row_match = D'($urandom);
            endcase
            step();
        end
        search_valid = 1'b0; match_ready = 1'b1;
        repeat (20) step();

        // wide instance corners
        w_row_match = '0; w_row_match[255] = 1'b1; w_search_valid = 1'b1; w_match_ready = 1'b1;
        wstep();
        w_search_valid = 1'b0;
        chk("w_bit255", 64'({w_match_valid, w_match_hit, w_match_addr, w_match_last}), 64'({2'b11, 8'd255, 1'b1}));
`ifdef CAM_MATCH_COUNT_EN
        chk("w_count1", 64'(w_match_count), 64'(1));
`endif
        wstep();
        chk("w_ready", 64'({w_search_ready, w_match_valid}), 64'(2'b10));
        w_row_match = '1; w_search_valid = 1'b1;
        wstep();
        w_search_valid = 1'b0;
`ifdef CAM_MATCH_COUNT_EN
        chk("w_count256", 64'(w_match_count), 64'(256));
`endif
        for (int i = 0; i < WD; i++) begin
            chk("w_seq", 64'({w_match_valid, w_match_addr, w_match_last}), 64'({1'b1, 8'(i), (i == WD - 1)}));
            wstep();
        end
        chk("w_done", 64'({w_search_ready, w_match_valid}), 64'(2'b10));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cam_match_resolver.md
# cam_match_resolver

Downstream consumer of the CAM row array: captures the per-row `row_match` vector produced by `CAM_DEPTH` CAM rows for one search and reports matching row addresses. It reports one address per handshake, lowest index first. A search with no hit produces a single miss response. Its output feeds the CAM lookup result path.

## Interface
- `CAM_DEPTH`, 16: number of CAM rows, which is the width of `row_match`. Legal range is 2–256.
- `ADDR_W`, `$clog2(CAM_DEPTH)`: width of the match address.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, asynchronous assert, active-low (0 = reset).
- `search_valid` input 1: a search result is present on `row_match` this cycle.
- `search_ready` output 1: the block can accept a search.
- `row_match` input CAM_DEPTH: bit i is the `row_match` of CAM row i. It is sampled only on accept.
- `match_valid` output 1: a response is presented.
- `match_ready` input 1: the consumer takes the response.
- `match_hit` output 1: 1 = `match_addr` is a matching row; 0 = miss response.
- `match_addr` output ADDR_W: lowest set index of the pending vector. It is 0 on a miss.
- `match_last` output 1: this is the final response for the current search.

## Operation
- State machine (`st`): IDLE, EMIT, MISS.
- IDLE
  - `search_ready`=1 and `match_valid`=0.
  - On `search_valid`&`search_ready`: `pend` <= `row_match`.
  - Next state is EMIT if `row_match`≠0, otherwise MISS.
- EMIT
  - `match_valid`=1, `match_hit`=1.
  - `match_addr`=priority_encode(`pend`), taking the lowest index.
  - `match_last`=1 when `pend` has exactly one bit set, i.e. (`pend` & (`pend`−1))==0.
  - On `match_valid`&`match_ready`: clear bit `match_addr` of `pend`.
  - If `match_last` is set, go to IDLE; otherwise stay in EMIT.
- MISS
  - `match_valid`=1, `match_hit`=0, `match_addr`=0, `match_last`=1.
  - On handshake, go to IDLE.
- `search_ready`=0 in EMIT and MISS, so a new search is never accepted while responses are outstanding. `search_valid` is ignored there.
- While `match_valid`=1 and `match_ready`=0, all response outputs hold stable.
- `row_match` changes outside the accept cycle have no effect.
- Reset values: `st`=IDLE, `pend`=0, `search_ready`=1, `match_valid`=0, `match_hit`=0, `match_addr`=0, `match_last`=0.
- Reset asserted mid-search abandons the search immediately (asynchronously). The block is in IDLE on the first clock after release.

## Timing
- Accept at edge t gives `match_valid`=1 in the cycle after edge t. Latency is 1 cycle.
- All outputs are decoded from registered `st`/`pend` only. There is no combinational path from inputs to outputs.
- With `match_ready` held at 1, K matches produce K consecutive response cycles.
- `search_ready` returns the cycle after the last handshake, so a back-to-back search period is K+1 cycles. A miss takes 2 cycles.
- CAM_DEPTH=256 priority encoding must close timing in a single cycle.

## Configuration
- `CAM_MATCH_COUNT_EN` defined:
  - Adds output `match_count` [ADDR_W:0] = popcount(`row_match`), registered on accept.
  - The value is held constant for the entire response sequence, including 0 on a miss.
  - Reset value is 0.
- `CAM_MATCH_COUNT_EN` undefined: the port and the popcount logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package `cam_pkg` holds:
  - the state encoding constants (IDLE=2'd0, EMIT=2'd1, MISS=2'd2);
  - the default `CAM_DEPTH`.
- Sub-module `cam_priority_enc`: purely combinational.
  - Parameters: `CAM_DEPTH`.
  - Input: `vec`.
  - Outputs: `idx` (lowest set bit) and `any`.
  - Instantiated once, on `pend`.

## Test plan
- Miss, CAM_DEPTH=16:
  - Stimulus: `row_match`=16'h0000 accepted, `match_ready`=1.
  - Required: one cycle later `match_valid`=1, `match_hit`=0, `match_addr`=0, `match_last`=1. `search_ready`=1 the following cycle.
- Multi-match ordering:
  - Stimulus: `row_match`=16'h8421, `match_ready`=1.
  - Required: addresses 0,5,10,15 on consecutive cycles, `match_last` only on 15. With the macro, `match_count`=4 throughout.
- Backpressure:
  - Stimulus: `row_match`=16'h0006, `match_ready` low for 3 cycles.
  - Required: addr 1 held stable for all 3 cycles, then addr 2 with `match_last`=1. `search_valid` pulses during EMIT are not accepted.
- Single/extreme rows:
  - Stimulus: `row_match`=16'h8000.
  - Required: addr 15, `match_last`=1 on the first response.
- Reset mid-search:
  - Stimulus: `row_match`=16'hFFFF, assert `rst`=0 after 2 responses.
  - Required: all outputs return to reset values immediately. After release, a search of 16'h0010 yields addr 4 `match_last`=1 with no stale addresses.
- Width corner:
  - Stimulus: CAM_DEPTH=256, `row_match` with only bit 255 set.
  - Required: `match_addr`=8'd255. With the macro, `match_count`=9'd1; all-ones input gives `match_count`=9'd256.
